// File: rtl/simeck_pkg.sv
// Shared Simeck32/64 definitions: round constants, state encoding and the round function.
// Used by both the encryptor and the decryptor tops.
package simeck_pkg;

   localparam int          WORDW         = 16;
   localparam int          SIMECK_ROUNDS = 32;
   localparam int          CNTW          = 5;
   localparam logic [15:0] SIMECK_C      = 16'hFFFC;
   // Bit i is z0[i] of the X^5+X^2+1 m-sequence seeded with 5'b11111
   localparam logic [31:0] SIMECK_Z0     = 32'h9A42BB1F;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXPAND  = 2'd1,
      DECRYPT = 2'd2,
      DONE    = 2'd3
   } simeck_state_e;

   function automatic logic [WORDW-1:0] simeck_rotl(input logic [WORDW-1:0] x, input int unsigned n);
      logic [2*WORDW-1:0] dbl;
      dbl = {x, x} << n;
      return dbl[2*WORDW-1:WORDW];
   endfunction

   function automatic logic [WORDW-1:0] simeck_f(input logic [WORDW-1:0] x);
      return (x & simeck_rotl(x, 5)) ^ simeck_rotl(x, 1);
   endfunction

   // One Feistel step (l,r) -> (r ^ f(l) ^ k, l), packed as {l,r}
   function automatic logic [2*WORDW-1:0] simeck_round(input logic [2*WORDW-1:0] lr,
                                                        input logic [WORDW-1:0]   k);
      logic [WORDW-1:0] l;
      logic [WORDW-1:0] r;
      l = lr[2*WORDW-1:WORDW];
      r = lr[WORDW-1:0];
      return {r ^ simeck_f(l) ^ k, l};
   endfunction

endpackage

// File: rtl/simeck_key_store.sv
// 32x16 round-key store: one synchronous write port and one combinational read port.
// Contents are deliberately not reset; the core tracks validity separately.
module simeck_key_store
   import simeck_pkg::*;
#(
   parameter int DEPTH = SIMECK_ROUNDS,
   parameter int AW    = CNTW
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WORDW-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WORDW-1:0] rdata_o
);

   logic [WORDW-1:0] mem_q [DEPTH];

   // Round-key write during expansion
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simeck_decrypt_core.sv
// Iterative Simeck32/64 decryptor: expands round keys once (optionally cached by key value),
// then runs 32 inverse rounds one per clock and returns plaintext over valid/ready.
module simeck_decrypt_core
   import simeck_pkg::*;
#(
   parameter int DDATAW    = 32,
   parameter int ROUNDS    = 32,
   parameter bit KEY_CACHE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       Key,
   input  logic              ct_valid,
   output logic              ct_ready,
   input  logic [DDATAW-1:0] ct,
   output logic              pt_valid,
   input  logic              pt_ready,
   output logic [DDATAW-1:0] pt,
   output logic              busy
);

   if (DDATAW != 2 * WORDW) begin : g_bad_width
      $error("simeck_decrypt_core: DDATAW must be 32");
   end
   if (ROUNDS != SIMECK_ROUNDS) begin : g_bad_rounds
      $error("simeck_decrypt_core: ROUNDS must be 32");
   end

   localparam logic [CNTW-1:0] LAST_IDX  = CNTW'(ROUNDS - 1);
   localparam logic [CNTW-1:0] FIRST_IDX = {CNTW{1'b0}};

   simeck_state_e    state_q, state_d;
   logic [CNTW-1:0]  i_q, i_d;
   logic [WORDW-1:0] l_q, l_d, r_q, r_d;
   logic [WORDW-1:0] k_q, k_d, t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
   logic [63:0]      key_q, key_d;
   logic             key_ok_q, key_ok_d;
   logic [DDATAW-1:0] pt_q, pt_d;
   logic             pt_valid_q, pt_valid_d;
   logic             ct_ready_q, busy_q;

   logic             accept_s;
   logic             cache_hit_s;
   logic             ks_we_s;
   logic             round_en_s;
   logic             pt_load_s;
   logic             pt_take_s;
   logic [WORDW-1:0] rk_s;
   logic [2*WORDW-1:0] round_out_s;

   assign cache_hit_s = KEY_CACHE && key_ok_q && (Key == key_q);
   assign accept_s    = ct_valid && (state_q == IDLE);

   simeck_key_store #(
      .DEPTH (SIMECK_ROUNDS),
      .AW    (CNTW)
   ) u_key_store (
      .clk     (clk),
      .we_i    (ks_we_s),
      .waddr_i (i_q),
      .wdata_i (k_q),
      .raddr_i (i_q),
      .rdata_o (rk_s)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ct_valid) begin
               state_d = cache_hit_s ? DECRYPT : EXPAND;
            end else begin
               state_d = IDLE;
            end
         end
         EXPAND: begin
            if (i_q == LAST_IDX) begin
               state_d = DECRYPT;
            end else begin
               state_d = EXPAND;
            end
         end
         DECRYPT: begin
            if (i_q == FIRST_IDX) begin
               state_d = DONE;
            end else begin
               state_d = DECRYPT;
            end
         end
         DONE: begin
            if (pt_valid_q && pt_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM control outputs
   always_comb begin
      ks_we_s    = 1'b0;
      round_en_s = 1'b0;
      pt_load_s  = 1'b0;
      pt_take_s  = 1'b0;
      case (state_q)
         IDLE:    ks_we_s    = 1'b0;
         EXPAND:  ks_we_s    = 1'b1;
         DECRYPT: round_en_s = 1'b1;
         DONE: begin
            if (!pt_valid_q) begin
               pt_load_s = 1'b1;
            end else begin
               pt_take_s = pt_ready;
            end
         end
         default: ks_we_s = 1'b0;
      endcase
   end

   // Datapath is held in swapped order (l_q = right half) so the inverse round has the forward form
   assign round_out_s = simeck_round({l_q, r_q}, rk_s);

   // Datapath next-state: counter, key schedule shift register, l/r, cache and output
   always_comb begin
      i_d        = i_q;
      l_d        = l_q;
      r_d        = r_q;
      k_d        = k_q;
      t0_d       = t0_q;
      t1_d       = t1_q;
      t2_d       = t2_q;
      key_d      = key_q;
      key_ok_d   = key_ok_q;
      pt_d       = pt_q;
      pt_valid_d = pt_valid_q;
      if (accept_s) begin
         key_d = Key;
         l_d   = ct[WORDW-1:0];
         r_d   = ct[2*WORDW-1:WORDW];
         {t2_d, t1_d, t0_d, k_d} = Key;
         if (cache_hit_s) begin
            i_d = LAST_IDX;
         end else begin
            i_d      = FIRST_IDX;
            key_ok_d = 1'b0;
         end
      end else if (ks_we_s) begin
         k_d  = t0_q;
         t0_d = t1_q;
         t1_d = t2_q;
         t2_d = k_q ^ simeck_f(t0_q) ^ SIMECK_C ^ {{(WORDW-1){1'b0}}, SIMECK_Z0[i_q]};
         if (i_q == LAST_IDX) begin
            key_ok_d = 1'b1;
            i_d      = LAST_IDX;
         end else begin
            i_d = i_q + 5'd1;
         end
      end else if (round_en_s) begin
         {l_d, r_d} = round_out_s;
         if (i_q != FIRST_IDX) begin
            i_d = i_q - 5'd1;
         end else begin
            i_d = i_q;
         end
      end else if (pt_load_s) begin
         pt_d       = {r_q, l_q};
         pt_valid_d = 1'b1;
      end else if (pt_take_s) begin
         pt_valid_d = 1'b0;
      end else begin
         pt_valid_d = pt_valid_q;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q        <= 5'd0;
         l_q        <= 16'd0;
         r_q        <= 16'd0;
         k_q        <= 16'd0;
         t0_q       <= 16'd0;
         t1_q       <= 16'd0;
         t2_q       <= 16'd0;
         key_q      <= 64'd0;
         key_ok_q   <= 1'b0;
         pt_q       <= 32'd0;
         pt_valid_q <= 1'b0;
         ct_ready_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         i_q        <= i_d;
         l_q        <= l_d;
         r_q        <= r_d;
         k_q        <= k_d;
         t0_q       <= t0_d;
         t1_q       <= t1_d;
         t2_q       <= t2_d;
         key_q      <= key_d;
         key_ok_q   <= key_ok_d;
         pt_q       <= pt_d;
         pt_valid_q <= pt_valid_d;
         ct_ready_q <= (state_d == IDLE);
         busy_q     <= (state_d == EXPAND) || (state_d == DECRYPT);
      end
   end

   assign ct_ready = ct_ready_q;
   assign busy     = busy_q;
   assign pt_valid = pt_valid_q;
   assign pt       = pt_q;

endmodule

// File: tb/tb_simeck_decrypt_core.sv
// Self-checking bench for simeck_decrypt_core against a word-level Simeck32/64 reference model.
module tb_simeck_decrypt_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] key;
   logic        ct_valid;
   logic        ct_ready;
   logic [31:0] ct;
   logic        pt_valid;
   logic        pt_ready;
   logic [31:0] pt;
   logic        busy;

   int          checks = 0;
   int          failures = 0;
   bit          cache_valid = 1'b0;
   logic [63:0] cache_key = 64'd0;

   always #5 clk = ~clk;

   simeck_decrypt_core #(.DDATAW(32), .ROUNDS(32), .KEY_CACHE(1'b1)) dut (
      .clk(clk), .rst(rst), .Key(key), .ct_valid(ct_valid), .ct_ready(ct_ready), .ct(ct),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt(pt), .busy(busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [15:0] mf(input logic [15:0] x);
      logic [15:0] r5;
      logic [15:0] r1;
      r5 = (x << 5) | (x >> 11);
      r1 = (x << 1) | (x >> 15);
      return (x & r5) ^ r1;
   endfunction

   function automatic logic [15:0] model_rk(input logic [63:0] k, input int idx);
      logic [15:0] ks [0:35];
      logic        s  [0:40];
      for (int n = 0; n < 5; n++) s[n] = 1'b1;
      for (int n = 0; n < 36; n++) s[n+5] = s[n+2] ^ s[n];
      ks[0] = k[15:0]; ks[1] = k[31:16]; ks[2] = k[47:32]; ks[3] = k[63:48];
      for (int n = 0; n < 28; n++) ks[n+4] = ks[n] ^ mf(ks[n+1]) ^ 16'hFFFC ^ {15'd0, s[n]};
      return ks[idx];
   endfunction

   function automatic logic [31:0] model_enc(input logic [63:0] k, input logic [31:0] p);
      logic [15:0] l, r, t;
      l = p[31:16]; r = p[15:0];
      for (int n = 0; n < 32; n++) begin
         t = l;
         l = r ^ mf(l) ^ model_rk(k, n);
         r = t;
      end
      return {l, r};
   endfunction

   function automatic logic [31:0] model_dec(input logic [63:0] k, input logic [31:0] c);
      logic [15:0] l, r, t;
      l = c[31:16]; r = c[15:0];
      for (int n = 31; n >= 0; n--) begin
         t = r;
         r = l ^ mf(r) ^ model_rk(k, n);
         l = t;
      end
      return {l, r};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic run_request(input logic [63:0] k, input logic [31:0] c, output int lat,
                              output int busy_cyc, output logic [31:0] p_obs, output bit timeout,
                              output int exp_lat);
      int w;
      timeout  = 1'b0;
      lat      = 0;
      busy_cyc = 0;
      w        = 0;
      exp_lat  = (cache_valid && (k == cache_key)) ? 33 : 65;
      while (ct_ready !== 1'b1 && w < 100) begin
         @(posedge clk); #1; w++;
      end
      key = k; ct = c; ct_valid = 1'b1;
      @(posedge clk); #1;
      ct_valid = 1'b0;
      key = {$urandom, $urandom};
      ct  = $urandom;
      if (busy === 1'b1) busy_cyc++;
      while (pt_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
         if (busy === 1'b1) busy_cyc++;
      end
      if (pt_valid !== 1'b1) begin
         timeout = 1'b1;
      end else begin
         cache_valid = 1'b1;
         cache_key   = k;
      end
      p_obs = pt;
   endtask

   task automatic release_pt();
      pt_ready = 1'b1;
      @(posedge clk); #1;
      pt_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ct_ready !== 1'b1) begin failures++; $display("FAIL reset_ct_ready: got %b want 1", ct_ready); end
      checks++; if (pt_valid !== 1'b0) begin failures++; $display("FAIL reset_pt_valid: got %b want 0", pt_valid); end
      checks++; if (pt !== 32'd0) begin failures++; $display("FAIL reset_pt: got %h want 0", pt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      cache_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_published();
      int lat, bc, el; logic [31:0] p; bit to;
      run_request(64'h1918111009080100, 32'h770d2c76, lat, bc, p, to, el);
      checks++; if (to) begin failures++; $display("FAIL pub_timeout: no pt_valid within %0d cycles", lat); end
      checks++; if (p !== 32'h65656877) begin failures++; $display("FAIL pub_pt: got %h want 65656877", p); end
      checks++; if (p !== model_dec(64'h1918111009080100, 32'h770d2c76)) begin failures++; $display("FAIL pub_model: got %h want %h", p, model_dec(64'h1918111009080100, 32'h770d2c76)); end
      checks++; if (lat !== 65) begin failures++; $display("FAIL pub_latency: got %0d want 65", lat); end
      checks++; if (bc !== 64) begin failures++; $display("FAIL pub_busy_cycles: got %0d want 64", bc); end
      release_pt();
      checks++; if (pt_valid !== 1'b0) begin failures++; $display("FAIL pub_release_valid: got %b want 0", pt_valid); end
      checks++; if (ct_ready !== 1'b1) begin failures++; $display("FAIL pub_release_ready: got %b want 1", ct_ready); end
   endtask

   task automatic test_cache_hit();
      int lat, bc, el; logic [31:0] p, d; bit to;
      d = $urandom;
      run_request(64'h1918111009080100, model_enc(64'h1918111009080100, d), lat, bc, p, to, el);
      checks++; if (to) begin failures++; $display("FAIL hit_timeout: no pt_valid"); end
      checks++; if (p !== d) begin failures++; $display("FAIL hit_pt: got %h want %h", p, d); end
      checks++; if (lat !== 33) begin failures++; $display("FAIL hit_latency: got %0d want 33", lat); end
      checks++; if (bc !== 32) begin failures++; $display("FAIL hit_busy_cycles: got %0d want 32", bc); end
      release_pt();
   endtask

   task automatic test_loopback();
      int lat, bc, el; logic [31:0] p; bit to;
      logic [31:0] data [2];
      data[0] = 32'h804A0C59; data[1] = 32'h11111111;
      for (int n = 0; n < 2; n++) begin
         run_request(64'h73bce979d5123456, model_enc(64'h73bce979d5123456, data[n]), lat, bc, p, to, el);
         checks++; if (p !== data[n]) begin failures++; $display("FAIL loop_pt%0d: got %h want %h", n, p, data[n]); end
         checks++; if (lat !== ((n == 0) ? 65 : 33)) begin failures++; $display("FAIL loop_latency%0d: got %0d want %0d", n, lat, (n == 0) ? 65 : 33); end
         release_pt();
      end
   endtask

   task automatic test_backpressure();
      int lat, bc, el, xfers; logic [31:0] p, d, c; bit to;
      d = $urandom;
      c = model_enc(64'h73bce979d5123456, d);
      run_request(64'h73bce979d5123456, c, lat, bc, p, to, el);
      checks++; if (p !== d) begin failures++; $display("FAIL bp_pt: got %h want %h", p, d); end
      ct_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         ct = $urandom;
         @(posedge clk); #1;
         checks++; if (pt !== d || pt_valid !== 1'b1 || ct_ready !== 1'b0) begin
            failures++; $display("FAIL bp_hold%0d: pt=%h valid=%b ready=%b want pt=%h valid=1 ready=0", n, pt, pt_valid, ct_ready, d);
         end
      end
      ct_valid = 1'b0;
      pt_ready = 1'b1;
      xfers = 0;
      for (int n = 0; n < 4; n++) begin
         if (pt_valid === 1'b1 && pt_ready === 1'b1) xfers++;
         @(posedge clk); #1;
      end
      pt_ready = 1'b0;
      checks++; if (xfers !== 1) begin failures++; $display("FAIL bp_transfers: got %0d want 1", xfers); end
      checks++; if (busy !== 1'b0 || ct_ready !== 1'b1) begin failures++; $display("FAIL bp_idle: busy=%b ready=%b want 0/1", busy, ct_ready); end
   endtask

   task automatic test_key_change();
      int lat, bc, el; logic [31:0] p, d; logic [63:0] k; bit to;
      k = {$urandom, $urandom};
      if (k == 64'h73bce979d5123456) k = ~k;
      d = $urandom;
      run_request(k, model_enc(k, d), lat, bc, p, to, el);
      checks++; if (p !== d) begin failures++; $display("FAIL keychg_pt: got %h want %h", p, d); end
      checks++; if (lat !== 65) begin failures++; $display("FAIL keychg_latency: got %0d want 65", lat); end
      release_pt();
   endtask

   task automatic test_reset_mid_expand();
      int lat, bc, el; logic [31:0] p, d, c; logic [63:0] k; bit to;
      k = {$urandom, $urandom};
      if (k == cache_key) k = ~k;
      d = $urandom;
      c = model_enc(k, d);
      key = k; ct = c; ct_valid = 1'b1;
      @(posedge clk); #1;
      ct_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (ct_ready !== 1'b1 || pt_valid !== 1'b0 || pt !== 32'd0 || busy !== 1'b0) begin
         failures++; $display("FAIL rst_mid_outputs: ready=%b valid=%b pt=%h busy=%b want 1/0/0/0", ct_ready, pt_valid, pt, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      cache_valid = 1'b0;
      run_request(k, c, lat, bc, p, to, el);
      checks++; if (p !== d) begin failures++; $display("FAIL rst_mid_pt: got %h want %h", p, d); end
      checks++; if (lat !== 65) begin failures++; $display("FAIL rst_mid_latency: got %0d want 65", lat); end
      release_pt();
   endtask

   task automatic test_random();
      int lat, bc, el; logic [31:0] p, d, c; logic [63:0] k; bit to;
      k = {$urandom, $urandom};
      for (int n = 0; n < 6; n++) begin
         if ($urandom_range(0, 1) == 0) k = {$urandom, $urandom};
         d = $urandom;
         c = model_enc(k, d);
         run_request(k, c, lat, bc, p, to, el);
         checks++; if (p !== d) begin failures++; $display("FAIL rand_pt%0d: got %h want %h", n, p, d); end
         checks++; if (lat !== el) begin failures++; $display("FAIL rand_latency%0d: got %0d want %0d", n, lat, el); end
         release_pt();
      end
   endtask

   initial begin
      rst = 1'b1; key = 64'd0; ct = 32'd0; ct_valid = 1'b0; pt_ready = 1'b0;
      test_reset();
      test_published();
      test_cache_hit();
      test_loopback();
      test_backpressure();
      test_key_change();
      test_reset_mid_expand();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
